// File: rtl/vga_multi_threshold_counter.sv
// Frame counter with zero detect and run-time programmable thresholds whose
// updates take effect only on a frame boundary; cascades via frame_wrap.
module vga_multi_threshold_counter #(
  parameter int COUNTER_SIZE   = 11,
  parameter int WHOLE_FRAME    = 1328,
  parameter int NUM_THRESHOLDS = 4,
  parameter logic [NUM_THRESHOLDS*COUNTER_SIZE-1:0] DEFAULT_THRESHOLDS =
    {11'd1200, 11'd1100, 11'd1040, 11'd800}
) (
  input  logic                                   control_clock,
  input  logic                                   control_reset_n,
  input  logic                                   count_enable,
  input  logic                                   sync_clear,
  input  logic                                   one_shot,
  input  logic                                   load_thresholds,
  input  logic [NUM_THRESHOLDS*COUNTER_SIZE-1:0] threshold_bus,
  output logic [COUNTER_SIZE-1:0]                count_value,
  output logic                                   zero_detected,
  output logic [NUM_THRESHOLDS-1:0]              threshold_detected,
  output logic [NUM_THRESHOLDS-1:0]              past_threshold,
  output logic                                   frame_wrap,
  output logic                                   done,
  output logic                                   update_pending
);

  localparam int TW = NUM_THRESHOLDS * COUNTER_SIZE;
  localparam logic [COUNTER_SIZE-1:0] LAST = COUNTER_SIZE'(WHOLE_FRAME - 1);

  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  function automatic logic [NUM_THRESHOLDS-1:0] match_eq(
    input logic [COUNTER_SIZE-1:0] c, input logic [TW-1:0] thr);
    logic [NUM_THRESHOLDS-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_THRESHOLDS; k++) r[k] = (c == thr[k*COUNTER_SIZE +: COUNTER_SIZE]);
    return r;
  endfunction

  // Count never exceeds LAST, so thresholds >= WHOLE_FRAME never compare true.
  function automatic logic [NUM_THRESHOLDS-1:0] match_ge(
    input logic [COUNTER_SIZE-1:0] c, input logic [TW-1:0] thr);
    logic [NUM_THRESHOLDS-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_THRESHOLDS; k++) r[k] = (c >= thr[k*COUNTER_SIZE +: COUNTER_SIZE]);
    return r;
  endfunction

  localparam logic [NUM_THRESHOLDS-1:0] RST_EQ = match_eq({COUNTER_SIZE{1'b0}}, DEFAULT_THRESHOLDS);
  localparam logic [NUM_THRESHOLDS-1:0] RST_GE = match_ge({COUNTER_SIZE{1'b0}}, DEFAULT_THRESHOLDS);

  state_t                    state_q, state_d;
  logic [COUNTER_SIZE-1:0]   count_q, count_d;
  logic [TW-1:0]             active_q, active_d;
  logic [TW-1:0]             shadow_q, shadow_d;
  logic                      pending_q, pending_d;
  logic                      zero_q, zero_d;
  logic                      wrap_q, wrap_d;
  logic [NUM_THRESHOLDS-1:0] eq_q, eq_d;
  logic [NUM_THRESHOLDS-1:0] ge_q, ge_d;
  logic                      boundary;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wrap_d    = 1'b0;
    boundary  = 1'b0;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (sync_clear) begin
      count_d  = '0;
      state_d  = S_RUN;
      boundary = 1'b1;
    end else if (count_enable && (state_q == S_RUN)) begin
      if (count_q != LAST) begin
        count_d = count_q + 1'b1;
      end else if (!one_shot) begin
        count_d  = '0;
        wrap_d   = 1'b1;
        boundary = 1'b1;
      end else begin
        state_d = S_DONE;
      end
    end

    if (load_thresholds) begin
      shadow_d  = threshold_bus;
      pending_d = 1'b1;
    end
    // Reading shadow_d lets a load on the boundary edge go straight to active.
    if (boundary) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end

    zero_d = (count_d == '0);
    eq_d   = match_eq(count_d, active_d);
    ge_d   = match_ge(count_d, active_d);
  end

  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      state_q   <= S_RUN;
      count_q   <= '0;
      active_q  <= DEFAULT_THRESHOLDS;
      shadow_q  <= DEFAULT_THRESHOLDS;
      pending_q <= 1'b0;
      zero_q    <= 1'b1;
      wrap_q    <= 1'b0;
      eq_q      <= RST_EQ;
      ge_q      <= RST_GE;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
      wrap_q    <= wrap_d;
      eq_q      <= eq_d;
      ge_q      <= ge_d;
    end
  end

  assign count_value        = count_q;
  assign zero_detected      = zero_q;
  assign threshold_detected = eq_q;
  assign past_threshold     = ge_q;
  assign frame_wrap         = wrap_q;
  assign done               = (state_q == S_DONE);
  assign update_pending     = pending_q;

endmodule

// File: tb/tb_vga_multi_threshold_counter.sv
// Directed bench for vga_multi_threshold_counter: frame counting, one-shot,
// frame-synchronous threshold updates, enable stalls and async reset.
module tb_vga_multi_threshold_counter;

  localparam int CS = 11;
  localparam int NT = 4;
  localparam int TW = CS * NT;
  localparam logic [TW-1:0] DEF = {11'd1200, 11'd1100, 11'd1040, 11'd800};
  localparam logic [TW-1:0] LD1 = {11'd1200, 11'd1100, 11'd1040, 11'd600};
  localparam logic [TW-1:0] LD2 = {11'd1200, 11'd1100, 11'd5,    11'd600};
  localparam logic [TW-1:0] LD3 = {11'd1400, 11'd1100, 11'd5,    11'd600};
  localparam logic [TW-1:0] LD4 = {11'd1400, 11'd1100, 11'd1040, 11'd800};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, clr, os, ld;
  logic [TW-1:0] bus;
  logic [CS-1:0] count_value;
  logic          zero_detected, frame_wrap, done, update_pending;
  logic [NT-1:0] threshold_detected, past_threshold;

  int checks = 0;
  int errors = 0;

  logic [CS-1:0] exp_c;
  logic [TW-1:0] exp_thr;
  logic          exp_wrap, exp_done, exp_pend;

  always #5 clk = ~clk;

  vga_multi_threshold_counter dut (
    .control_clock      (clk),
    .control_reset_n    (rst_n),
    .count_enable       (en),
    .sync_clear         (clr),
    .one_shot           (os),
    .load_thresholds    (ld),
    .threshold_bus      (bus),
    .count_value        (count_value),
    .zero_detected      (zero_detected),
    .threshold_detected (threshold_detected),
    .past_threshold     (past_threshold),
    .frame_wrap         (frame_wrap),
    .done               (done),
    .update_pending     (update_pending)
  );

  function automatic logic [NT-1:0] f_eq(input logic [CS-1:0] c, input logic [TW-1:0] t);
    logic [NT-1:0] r;
    for (int k = 0; k < NT; k++) r[k] = (c == t[k*CS +: CS]);
    return r;
  endfunction

  function automatic logic [NT-1:0] f_ge(input logic [CS-1:0] c, input logic [TW-1:0] t);
    logic [NT-1:0] r;
    for (int k = 0; k < NT; k++) r[k] = (c >= t[k*CS +: CS]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 16'(count_value),        16'(exp_c));
    chk({tag, ".zero"},  16'(zero_detected),      16'(exp_c == '0));
    chk({tag, ".det"},   16'(threshold_detected), 16'(f_eq(exp_c, exp_thr)));
    chk({tag, ".past"},  16'(past_threshold),     16'(f_ge(exp_c, exp_thr)));
    chk({tag, ".wrap"},  16'(frame_wrap),         16'(exp_wrap));
    chk({tag, ".done"},  16'(done),               16'(exp_done));
    chk({tag, ".pend"},  16'(update_pending),     16'(exp_pend));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free-running enabled counting for n edges.
  task automatic scan(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      exp_c    = (exp_c == 11'd1327) ? 11'd0 : exp_c + 11'd1;
      exp_wrap = (exp_c == 11'd0);
      check_all(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; os = 1'b0; ld = 1'b0; bus = '0;
    exp_c = '0; exp_thr = DEF; exp_wrap = 1'b0; exp_done = 1'b0; exp_pend = 1'b0;
    repeat (3) tick();
    check_all("reset");

    // Full frame with defaults, wrap pulse on edge 1328, then single pulse.
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    scan("frame0", 1328);
    chk("wrap_at_1328", 16'(frame_wrap), 16'd1);
    scan("after_wrap", 1);

    // One-shot: hold at end, ignore one_shot drop, restart only via sync_clear.
    os = 1'b1;
    scan("oneshot_run", 1326);
    chk("oneshot_end", 16'(count_value), 16'd1327);
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_done = 1'b1;
      exp_wrap = 1'b0;
      check_all("oneshot_hold");
      if (i == 9) os = 1'b0;
    end
    clr = 1'b1;
    tick();
    exp_c = '0; exp_done = 1'b0; exp_wrap = 1'b0;
    check_all("clear_done");
    clr = 1'b0;
    scan("resume", 1);

    // Load mid-frame: no effect until the wrap.
    scan("to500", 499);
    ld = 1'b1; bus = LD1;
    tick();
    exp_c = 11'd501; exp_pend = 1'b1; exp_wrap = 1'b0;
    check_all("load_mid");
    ld = 1'b0;
    scan("old_frame", 826);
    tick();
    exp_c = '0; exp_wrap = 1'b1; exp_thr = LD1; exp_pend = 1'b0;
    check_all("wrap_apply");
    scan("new_frame", 600);
    chk("det_600", 16'(threshold_detected), 16'b0001);

    // Load coincident with the wrap edge goes straight to active.
    scan("to_end", 727);
    ld = 1'b1; bus = LD2;
    tick();
    exp_c = '0; exp_wrap = 1'b1; exp_thr = LD2; exp_pend = 1'b0;
    check_all("load_on_wrap");
    ld = 1'b0;
    scan("to5", 5);
    chk("det_5", 16'(threshold_detected), 16'b0010);
    chk("past_5", 16'(past_threshold), 16'b0010);

    // Alternate enable for two frames.
    clr = 1'b1;
    tick();
    exp_c = '0; exp_wrap = 1'b0;
    check_all("clear_run");
    clr = 1'b0;
    for (int i = 0; i < 5312; i++) begin
      en = (i % 2 == 0);
      tick();
      if (en) begin
        exp_c    = (exp_c == 11'd1327) ? 11'd0 : exp_c + 11'd1;
        exp_wrap = (exp_c == 11'd0);
      end else begin
        exp_wrap = 1'b0;
      end
      check_all("toggle");
    end
    chk("toggle_end", 16'(count_value), 16'd0);

    // Async reset mid-frame discards a pending load and active thresholds.
    en = 1'b1;
    scan("to900", 900);
    ld = 1'b1; bus = LD3;
    tick();
    exp_c = 11'd901; exp_pend = 1'b1; exp_wrap = 1'b0;
    check_all("load_900");
    ld = 1'b0; en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_c = '0; exp_thr = DEF; exp_pend = 1'b0; exp_wrap = 1'b0; exp_done = 1'b0;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("post_reset_idle");

    // Threshold beyond the frame never matches.
    clr = 1'b1; ld = 1'b1; bus = LD4;
    tick();
    exp_thr = LD4;
    check_all("clear_load");
    clr = 1'b0; ld = 1'b0; en = 1'b1;
    scan("big_thr", 1328);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_multi_threshold_counter.md
Name: vga_multi_threshold_counter

Overview:
- Parametrised successor to the single zero/threshold frame counter used by the VGA controller.
- Counts 0..WHOLE_FRAME-1 on control_clock. Detects zero and NUM_THRESHOLDS independent thresholds, programmable at run time, with frame-synchronous update.
- Adds enable, synchronous clear, one-shot mode and a wrap pulse for cascading a horizontal counter into a vertical counter.
- Sits under the VGA timing generator and produces sync/blank boundaries.

Parameters:
- COUNTER_SIZE, 11, counter and threshold width in bits.
- WHOLE_FRAME, 1328, frame length in counts; count range 0..WHOLE_FRAME-1; must be >= 2 and <= 2^COUNTER_SIZE.
- NUM_THRESHOLDS, 4, number of threshold comparators; 1..8.
- DEFAULT_THRESHOLDS, {11'd1200, 11'd1100, 11'd1040, 11'd800}, packed reset values; slot k is at bits [k*COUNTER_SIZE +: COUNTER_SIZE].

Ports:
- control_clock  in  1  sole clock, rising edge.
- control_reset_n  in  1  asynchronous active-low reset.
- count_enable  in  1  advance the counter this cycle.
- sync_clear  in  1  force count to 0 next edge; overrides count_enable.
- one_shot  in  1  0 = free-running wrap; 1 = stop at WHOLE_FRAME-1.
- load_thresholds  in  1  capture threshold_bus into the shadow registers.
- threshold_bus  in  NUM_THRESHOLDS*COUNTER_SIZE  new threshold values.
- count_value  out  COUNTER_SIZE  current count.
- zero_detected  out  1  high while count_value == 0.
- threshold_detected  out  NUM_THRESHOLDS  bit k high while count_value == active threshold k.
- past_threshold  out  NUM_THRESHOLDS  bit k high while count_value >= active threshold k.
- frame_wrap  out  1  one-cycle pulse coincident with count_value == 0 after a wrap.
- done  out  1  one-shot finished; held at WHOLE_FRAME-1.
- update_pending  out  1  shadow thresholds loaded but not yet active.

Behaviour:
- All outputs are registered. Detection flags are computed from the next-state count and active thresholds, so they are exactly coincident with count_value. There is no combinational path from inputs to outputs.
- Reset (async, control_reset_n = 0) gives:
  - count_value = 0, zero_detected = 1, frame_wrap = 0, done = 0, update_pending = 0.
  - Active and shadow thresholds = DEFAULT_THRESHOLDS; threshold_detected and past_threshold decoded from count 0.
- Release is used synchronously; the first count occurs on the first edge with count_enable = 1.
- Next-count priority:
  - sync_clear: count <= 0, done <= 0, frame_wrap <= 0.
  - else count_enable and count < WHOLE_FRAME-1: count + 1.
  - else count_enable and count == WHOLE_FRAME-1 and one_shot = 0: count <= 0, frame_wrap <= 1.
  - else count_enable and count == WHOLE_FRAME-1 and one_shot = 1: hold, done <= 1.
  - else hold.
- Counting states: RUN (counting or enable-stalled) and DONE (one_shot held at end). DONE exits only via sync_clear or reset.
- Clearing one_shot while in DONE does not restart the counter; only sync_clear restarts.
- Threshold update:
  - load_thresholds = 1: shadow <= threshold_bus, update_pending <= 1.
  - Shadow is copied to active on the frame boundary, i.e. any edge where the count becomes 0 by wrap or sync_clear; update_pending then clears.
  - Load and boundary on the same edge: threshold_bus goes directly to active, update_pending = 0.
  - Repeated loads before the boundary: the last one wins.
  - Never applied mid-frame, so no partial-frame glitch.
- A threshold >= WHOLE_FRAME never matches; its past_threshold bit stays 0.
- A threshold of 0 makes threshold_detected[k] coincident with zero_detected.
- Multiple thresholds may be equal; each bit asserts independently.
- Comparisons are unsigned, full COUNTER_SIZE width. No arithmetic overflow: count never exceeds WHOLE_FRAME-1.
- count_enable low: all outputs hold their values. frame_wrap is a single pulse even if enable then stalls at 0.
- Reset mid-frame returns everything, including active thresholds, to the reset values above.

Test Plan:
- Reset then count_enable = 1 with defaults:
  - count_value reaches 1327 then 0.
  - frame_wrap pulses only at count 0, cycle 1328 after the first count.
  - threshold_detected[0] is high exactly at count 800; past_threshold[3] is high for counts 1200..1327.
- one_shot = 1:
  - count holds at 1327 with done = 1 for 20 cycles and no frame_wrap.
  - sync_clear gives count 0, done 0; counting resumes.
- load_thresholds at count 500 with slot 0 = 600:
  - No match at 600 in the current frame; update_pending = 1.
  - After the wrap, threshold_detected[0] fires at 600 and update_pending = 0.
- load_thresholds asserted on the wrap edge with slot 1 = 5: the match occurs at count 5 of the immediately following frame.
- Toggle count_enable 1/0 every cycle for two frames:
  - Count advances only on enabled edges; the frame takes 2656 cycles.
  - Flags stay aligned with count_value.
- Assert control_reset_n low at count 900 after loading thresholds:
  - Immediate count 0, defaults restored; zero_detected = 1.
  - A threshold slot set to 1400 (>= WHOLE_FRAME) never asserts.
